// File: rtl/cpu_trace_emitter.sv
// ============================================================================
// Module   : cpu_trace_emitter
// Brief    : Serialises CPU write-back records into the ASCII trace stream
//            ("^t@pc: $grf <= data#" / "^t@pc: *addr <= data#").
//            Option macro: TRACE_LEADING_ZERO_EN (4-digit time, 2-digit grf).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_trace_emitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_reg,
  input  logic [13:0] time_val,
  input  logic [31:0] pc,
  input  logic [4:0]  grf,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic [7:0]  char,
  output logic        char_valid,
  input  logic        char_ready
);

  localparam logic [13:0] c_time_max = 14'd9999;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CARET = 4'd1,
    S_TIME  = 4'd2,
    S_AT    = 4'd3,
    S_PC    = 4'd4,
    S_COLON = 4'd5,
    S_SP1   = 4'd6,
    S_KIND  = 4'd7,
    S_IDX   = 4'd8,
    S_SP2   = 4'd9,
    S_LT    = 4'd10,
    S_EQ    = 4'd11,
    S_SP3   = 4'd12,
    S_DATA  = 4'd13,
    S_HASH  = 4'd14
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [2:0]      r_cnt;
  logic [2:0]      w_next_cnt;
  logic [7:0]      r_char;
  logic            r_char_valid;

  logic            r_is_reg;
  logic [31:0]     r_pc;
  logic [31:0]     r_addr;
  logic [31:0]     r_data;
  logic [3:0][3:0] r_tdig;
  logic [1:0]      r_tlast;
  logic [3:0]      r_gtens;
  logic [3:0]      r_gones;
  logic            r_glast;

  logic            w_accept;
  logic            w_idx_last;
  logic [13:0]     w_tsat;
  logic [3:0]      w_d3, w_d2, w_d1, w_d0;
  logic [1:0]      w_tlast;
  logic            w_glast;

  // Binary-to-decimal conversion happens in the accept cycle itself.
  assign w_tsat = (time_val > c_time_max) ? c_time_max : time_val;
  assign w_d3   = 4'(w_tsat / 14'd1000);
  assign w_d2   = 4'((w_tsat / 14'd100) % 14'd10);
  assign w_d1   = 4'((w_tsat / 14'd10) % 14'd10);
  assign w_d0   = 4'(w_tsat % 14'd10);

`ifdef TRACE_LEADING_ZERO_EN
  assign w_tlast = 2'd3;
  assign w_glast = 1'b1;
`else
  assign w_tlast = (w_d3 != 4'd0) ? 2'd3 :
                   (w_d2 != 4'd0) ? 2'd2 :
                   (w_d1 != 4'd0) ? 2'd1 : 2'd0;
  assign w_glast = (grf >= 5'd10);
`endif

  assign in_ready   = (r_state == S_IDLE) || ((r_state == S_HASH) && char_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_idx_last = r_is_reg ? (r_cnt[0] == r_glast) : (r_cnt == 3'd7);
  assign char       = r_char;
  assign char_valid = r_char_valid;

  function automatic logic [7:0] dec_char(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  // Nibble 7-cnt of the word, i.e. most significant digit first.
  function automatic logic [7:0] hex_char(input logic [31:0] w, input logic [2:0] cnt);
    logic [3:0] n;
    n = w[{~cnt, 2'b00} +: 4];
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [7:0] char_of(input state_t st, input logic [2:0] cnt);
    logic [7:0] c;
    c = 8'h00;
    case (st)
      S_CARET: c = "^";
      S_TIME:  c = dec_char(r_tdig[r_tlast - cnt[1:0]]);
      S_AT:    c = "@";
      S_PC:    c = hex_char(r_pc, cnt);
      S_COLON: c = ":";
      S_KIND:  c = r_is_reg ? "$" : "*";
      S_IDX:   c = r_is_reg ? dec_char((r_glast && cnt == 3'd0) ? r_gtens : r_gones)
                            : hex_char(r_addr, cnt);
      S_SP1, S_SP2, S_SP3: c = " ";
      S_LT:    c = "<";
      S_EQ:    c = "=";
      S_DATA:  c = hex_char(r_data, cnt);
      S_HASH:  c = "#";
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (r_state == S_IDLE) begin
      if (in_valid) begin
        w_next_state = S_CARET;
        w_next_cnt   = 3'd0;
      end
    end else if (char_ready) begin
      w_next_cnt = 3'd0;
      case (r_state)
        S_CARET: w_next_state = S_TIME;
        S_TIME:  if (r_cnt[1:0] == r_tlast) w_next_state = S_AT; else w_next_cnt = r_cnt + 3'd1;
        S_AT:    w_next_state = S_PC;
        S_PC:    if (r_cnt == 3'd7) w_next_state = S_COLON; else w_next_cnt = r_cnt + 3'd1;
        S_COLON: w_next_state = S_SP1;
        S_SP1:   w_next_state = S_KIND;
        S_KIND:  w_next_state = S_IDX;
        S_IDX:   if (w_idx_last) w_next_state = S_SP2; else w_next_cnt = r_cnt + 3'd1;
        S_SP2:   w_next_state = S_LT;
        S_LT:    w_next_state = S_EQ;
        S_EQ:    w_next_state = S_SP3;
        S_SP3:   w_next_state = S_DATA;
        S_DATA:  if (r_cnt == 3'd7) w_next_state = S_HASH; else w_next_cnt = r_cnt + 3'd1;
        S_HASH:  w_next_state = in_valid ? S_CARET : S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // The character for the next state is computed here so char is registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_char       <= 8'h00;
      r_char_valid <= 1'b0;
      r_is_reg     <= 1'b0;
      r_pc         <= 32'd0;
      r_addr       <= 32'd0;
      r_data       <= 32'd0;
      r_tdig       <= '0;
      r_tlast      <= 2'd0;
      r_gtens      <= 4'd0;
      r_gones      <= 4'd0;
      r_glast      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_char       <= char_of(w_next_state, w_next_cnt);
      r_char_valid <= (w_next_state != S_IDLE);
      if (w_accept) begin
        r_is_reg <= is_reg;
        r_pc     <= pc;
        r_addr   <= addr;
        r_data   <= data;
        r_tdig   <= {w_d3, w_d2, w_d1, w_d0};
        r_tlast  <= w_tlast;
        r_gtens  <= 4'(grf / 5'd10);
        r_gones  <= 4'(grf % 5'd10);
        r_glast  <= w_glast;
      end
    end
  end

endmodule

`default_nettype wire
